// File: rtl/drive_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : drive_param_pkg
//  Description : Shared definitions for the drive parameter loader and the
//                LPF / PWM preconditioner instances it feeds. Holds the BRAM
//                word field offsets, the loader state encoding and the
//                default array geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package drive_param_pkg;

    // Field offsets inside the 32-bit parameter BRAM word.
    localparam int unsigned c_DUTY_LSB      = 0;
    localparam int unsigned c_PHASE_LSB     = 16;

    // Default geometry shared with the downstream LPF / preconditioner.
    localparam int unsigned c_DEF_WIDTH     = 13;
    localparam int unsigned c_DEF_DEPTH     = 249;
    localparam int unsigned c_DEF_ADDR_W    = 8;
    localparam int unsigned c_DEF_RD_LAT    = 2;
    localparam int unsigned c_DEF_DUTY_MAX  = 2500;

    // Loader sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        ARMED = 2'd3
    } state_t;

endpackage : drive_param_pkg
`default_nettype wire

// File: rtl/drive_param_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : drive_param_loader_if
//  Description : Bundle between the parameter loader and its surroundings:
//                CPU update request, period strobe, BRAM read port, status
//                and the active duty/phase arrays.
//                  update_req : single-cycle request for a new parameter set
//                  start      : period boundary strobe
//                  bram_en    : BRAM read enable
//                  bram_addr  : BRAM read address (transducer index)
//                  bram_dout  : BRAM read data (duty / phase fields)
//                  busy       : load in progress, not yet committed
//                  done       : one-cycle commit pulse
//                  duty/phase : active arrays, entry i = transducer i
//                master = loader side, slave = CPU/BRAM/PWM side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface drive_param_loader_if
    import drive_param_pkg::*;
#(
    parameter int unsigned WIDTH  = c_DEF_WIDTH,
    parameter int unsigned DEPTH  = c_DEF_DEPTH,
    parameter int unsigned ADDR_W = c_DEF_ADDR_W
) ();

    logic                         update_req;
    logic                         start;
    logic                         bram_en;
    logic [ADDR_W-1:0]            bram_addr;
    logic [31:0]                  bram_dout;
    logic                         busy;
    logic                         done;
    logic [DEPTH-1:0][WIDTH-1:0]  duty;
    logic [DEPTH-1:0][WIDTH-1:0]  phase;

    modport master (
        input  update_req,
        input  start,
        input  bram_dout,
        output bram_en,
        output bram_addr,
        output busy,
        output done,
        output duty,
        output phase
    );

    modport slave (
        output update_req,
        output start,
        output bram_dout,
        input  bram_en,
        input  bram_addr,
        input  busy,
        input  done,
        input  duty,
        input  phase
    );

endinterface : drive_param_loader_if
`default_nettype wire

// File: rtl/drive_param_loader_bram_rd_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : bram_rd_pipe
//  Description : RD_LAT-deep shift register of {valid, idx}. An index issued
//                to the BRAM on cycle n emerges on cycle n+RD_LAT, exactly
//                when the matching read data is on the BRAM output.
//                  clk, rst_n : clock, async active-low reset
//                  i_valid    : address issued this cycle
//                  i_idx      : issued address / entry index
//                  o_valid    : capture strobe aligned to read data
//                  o_idx      : entry index for the data now on the bus
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_rd_pipe #(
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned IDX_W  = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_valid,
    input  wire logic [IDX_W-1:0] i_idx,
    output logic                  o_valid,
    output logic      [IDX_W-1:0] o_idx
);

    logic [RD_LAT-1:0]            r_valid;
    logic [RD_LAT-1:0][IDX_W-1:0] r_idx;

    generate
        if (RD_LAT == 1) begin : g_lat_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= '0;
                    r_idx   <= '0;
                end else begin
                    r_valid[0] <= i_valid;
                    r_idx[0]   <= i_idx;
                end
            end
        end else begin : g_lat_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= '0;
                    r_idx   <= '0;
                end else begin
                    r_valid <= {r_valid[RD_LAT-2:0], i_valid};
                    r_idx   <= {r_idx[RD_LAT-2:0], i_idx};
                end
            end
        end
    endgenerate

    assign o_valid = r_valid[RD_LAT-1];
    assign o_idx   = r_idx[RD_LAT-1];

endmodule : bram_rd_pipe
`default_nettype wire

// File: rtl/drive_param_loader.sv
`default_nettype none
// ============================================================================
//  Module      : drive_param_loader
//  Description : On an update request, streams DEPTH duty/phase entries from
//                the parameter BRAM into a shadow buffer, then commits the
//                whole buffer to the active arrays on the next period
//                boundary (start) so the PWM chain never sees a mixed set.
//                Requests arriving while a load is in flight collapse into a
//                single pending load that starts right after the commit.
//                  clk   : PWM-domain clock
//                  rst_n : asynchronous active-low reset
//                  bus   : loader-side view of drive_param_loader_if
//  Revision    : 1.0 - initial release
// ============================================================================
module drive_param_loader
    import drive_param_pkg::*;
#(
    parameter int unsigned      WIDTH    = c_DEF_WIDTH,
    parameter int unsigned      DEPTH    = c_DEF_DEPTH,
    parameter int unsigned      ADDR_W   = c_DEF_ADDR_W,   // 2**ADDR_W >= DEPTH
    parameter int unsigned      RD_LAT   = c_DEF_RD_LAT,   // 1..3
    parameter logic [WIDTH-1:0] DUTY_MAX = WIDTH'(c_DEF_DUTY_MAX)
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    drive_param_loader_if.master bus
);

    localparam logic [ADDR_W-1:0] c_LAST_IDX   = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        c_DRAIN_LAST = 2'(RD_LAT - 1);
    localparam logic [31:0]       c_FIELD_MASK = 32'((64'd1 << WIDTH) - 64'd1);
    localparam logic [31:0]       c_USED_MASK  = (c_FIELD_MASK << c_DUTY_LSB) |
                                                 (c_FIELD_MASK << c_PHASE_LSB);

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t            r_state,   w_state_next;
    logic [ADDR_W-1:0] r_idx,     w_idx_next;
    logic [1:0]        r_drain,   w_drain_next;
    logic              r_pending, w_pending_next;
    logic              w_commit;

    // ------------------------------------------------------------------
    // Capture path
    // ------------------------------------------------------------------
    logic              w_cap_valid;
    logic [ADDR_W-1:0] w_cap_idx;
    logic [WIDTH-1:0]  w_raw_duty;
    logic [WIDTH-1:0]  w_cap_duty;
    logic [WIDTH-1:0]  w_cap_phase;
    logic              w_unused_bits;

    logic [DEPTH-1:0][WIDTH-1:0] r_sh_duty;
    logic [DEPTH-1:0][WIDTH-1:0] r_sh_phase;
    logic [DEPTH-1:0][WIDTH-1:0] r_duty;
    logic [DEPTH-1:0][WIDTH-1:0] r_phase;

    // Index/valid pipeline matched to the BRAM read latency.
    bram_rd_pipe #(
        .RD_LAT (RD_LAT),
        .IDX_W  (ADDR_W)
    ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (r_state == FETCH),
        .i_idx   (r_idx),
        .o_valid (w_cap_valid),
        .o_idx   (w_cap_idx)
    );

    assign w_raw_duty    = bus.bram_dout[c_DUTY_LSB  +: WIDTH];
    assign w_cap_phase   = bus.bram_dout[c_PHASE_LSB +: WIDTH];
    assign w_cap_duty    = (w_raw_duty > DUTY_MAX) ? DUTY_MAX : w_raw_duty;
    // Bits outside the two fields carry no meaning for this block.
    assign w_unused_bits = ^(bus.bram_dout & ~c_USED_MASK);

    // ------------------------------------------------------------------
    // Next-state / output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_idx_next     = r_idx;
        w_drain_next   = r_drain;
        w_pending_next = r_pending;
        w_commit       = 1'b0;

        // Any request outside IDLE (including the commit cycle itself) is
        // remembered; several of them still mean just one more load.
        if ((r_state != IDLE) && bus.update_req) begin
            w_pending_next = 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (bus.update_req || r_pending) begin
                    w_state_next   = FETCH;
                    w_idx_next     = '0;
                    w_pending_next = 1'b0;
                end
            end
            FETCH: begin
                if (r_idx == c_LAST_IDX) begin
                    w_state_next = DRAIN;
                    w_idx_next   = '0;
                    w_drain_next = '0;
                end else begin
                    w_idx_next   = r_idx + ADDR_W'(1);
                end
            end
            DRAIN: begin
                // RD_LAT cycles after the last address the final word has
                // been written to the shadow buffer.
                if (r_drain == c_DRAIN_LAST) begin
                    w_state_next = ARMED;
                end else begin
                    w_drain_next = r_drain + 2'd1;
                end
            end
            ARMED: begin
                if (bus.start) begin
                    w_commit     = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.bram_en   = (r_state == FETCH);
    assign bus.bram_addr = r_idx;
    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = w_commit;
    assign bus.duty      = r_duty;
    assign bus.phase     = r_phase;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_drain   <= '0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_drain   <= w_drain_next;
            r_pending <= w_pending_next;
        end
    end

    // ------------------------------------------------------------------
    // Shadow capture and atomic commit
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_duty  <= '0;
            r_sh_phase <= '0;
            r_duty     <= '0;
            r_phase    <= '0;
        end else begin
            for (int e = 0; e < int'(DEPTH); e++) begin
                if (w_cap_valid && (w_cap_idx == ADDR_W'(e))) begin
                    r_sh_duty[e]  <= w_cap_duty;
                    r_sh_phase[e] <= w_cap_phase;
                end
            end
            if (w_commit) begin
                r_duty  <= r_sh_duty;
                r_phase <= r_sh_phase;
            end
        end
    end

endmodule : drive_param_loader
`default_nettype wire

// File: tb/tb_drive_param_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_drive_param_loader
//  Description : Self-checking bench for drive_param_loader (DEPTH=4,
//                RD_LAT=2). A latency-accurate BRAM model serves reads; a
//                reference model tracks each load as "cycles since
//                acceptance" and predicts the read enable, address, busy,
//                done and active arrays every cycle. Directed scenarios are
//                followed by randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_drive_param_loader;

    localparam int unsigned      WIDTH    = 13;
    localparam int unsigned      DEPTH    = 4;
    localparam int unsigned      ADDR_W   = 8;
    localparam int unsigned      RD_LAT   = 2;
    localparam logic [WIDTH-1:0] DUTY_MAX = 13'd2500;
    // Cycles from acceptance until the set is armed.
    localparam int               c_LOAD   = DEPTH + RD_LAT + 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    drive_param_loader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    drive_param_loader #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .RD_LAT   (RD_LAT),
        .DUTY_MAX (DUTY_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- BRAM model: data RD_LAT cycles after address ------
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] rd_pipe [RD_LAT];
    logic [31:0]       bram_word;

    always @(posedge clk) begin
        if (bus.bram_en) rd_pipe[0] <= bus.bram_addr;
        for (int k = 1; k < int'(RD_LAT); k++) rd_pipe[k] <= rd_pipe[k-1];
    end

    always_comb begin
        bram_word = 32'hDEAD_BEEF;
        for (int e = 0; e < int'(DEPTH); e++)
            if (rd_pipe[RD_LAT-1] == ADDR_W'(e)) bram_word = mem[e];
    end
    assign bus.bram_dout = bram_word;

    // ---------------- Reference model -----------------------------------
    bit m_loading;          // a load has been accepted and not yet committed
    int m_t;                // cycles elapsed since acceptance (1 = first FETCH cycle)
    bit m_pend;             // one more load requested
    int exp_duty  [DEPTH];
    int exp_phase [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;
    int n_done_seen = 0;
    int cyc = 0;

    function automatic int sat(input int v);
        return (v > int'(DUTY_MAX)) ? int'(DUTY_MAX) : v;
    endfunction

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s cyc=%0d: got %0d expected %0d", name, cyc, got, want);
    endtask

    task automatic model_reset();
        m_loading = 1'b0;
        m_t       = 0;
        m_pend    = 1'b0;
        for (int e = 0; e < int'(DEPTH); e++) begin
            exp_duty[e]  = 0;
            exp_phase[e] = 0;
        end
    endtask

    // Advance the model by one clock using the inputs of the cycle just ended.
    task automatic model_step();
        if (m_loading) begin
            if (bus.update_req) m_pend = 1'b1;
            if (m_t >= c_LOAD && bus.start) begin
                for (int e = 0; e < int'(DEPTH); e++) begin
                    exp_duty[e]  = sat(int'(mem[e][WIDTH-1:0]));
                    exp_phase[e] = int'(mem[e][16 +: WIDTH]);
                end
                m_loading = 1'b0;
            end else begin
                m_t++;
            end
        end else if (bus.update_req || m_pend) begin
            m_loading = 1'b1;
            m_t       = 1;
            m_pend    = 1'b0;
        end
    endtask

    task automatic compare();
        bit exp_en;
        exp_en = m_loading && (m_t >= 1) && (m_t <= int'(DEPTH));
        check("bram_en", int'(bus.bram_en), int'(exp_en));
        if (exp_en) check("bram_addr", int'(bus.bram_addr), m_t - 1);
        check("busy", int'(bus.busy), int'(m_loading));
        check("done", int'(bus.done), int'(m_loading && (m_t >= c_LOAD) && bus.start));
        for (int e = 0; e < int'(DEPTH); e++) begin
            check("duty",  int'(bus.duty[e]),  exp_duty[e]);
            check("phase", int'(bus.phase[e]), exp_phase[e]);
        end
        if (bus.done) n_done_seen++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            cyc++;
            if (rst_n) model_step();
            @(negedge clk);
            if (!rst_n) model_reset();
            compare();
        end
    end

    // ---------------- Stimulus -------------------------------------------
    task automatic tick(input bit req, input bit st);
        bus.update_req = req;
        bus.start      = st;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input int d, input int p);
        logic [31:0] w;
        w = '0;
        w[WIDTH-1:0]  = WIDTH'(d);
        w[16 +: WIDTH] = WIDTH'(p);
        return w;
    endfunction

    int d0;

    initial begin
        bus.update_req = 1'b0;
        bus.start      = 1'b0;
        for (int e = 0; e < int'(DEPTH); e++) mem[e] = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) tick(0, 0);
        rst_n = 1'b1;

        // Idle after reset: start strobes change nothing.
        tick(0, 1); tick(0, 0); tick(0, 1); tick(0, 0);
        check("idle_busy", int'(bus.busy), 0);
        check("idle_duty0", int'(bus.duty[0]), 0);

        // Basic load; junk in the ignored bits.
        for (int e = 0; e < int'(DEPTH); e++)
            mem[e] = word(100 * (e + 1), 10 * (e + 1)) | 32'hE000_E000;
        d0 = n_done_seen;
        tick(1, 0);
        repeat (10) tick(0, 0);
        check("pre_start_duty3", int'(bus.duty[3]), 0);
        tick(0, 1);
        tick(0, 0);
        for (int e = 0; e < int'(DEPTH); e++) begin
            check("lit_duty",  int'(bus.duty[e]),  100 * (e + 1));
            check("lit_phase", int'(bus.phase[e]), 10 * (e + 1));
        end
        check("done_count_basic", n_done_seen - d0, 1);

        // Saturation of an oversized duty entry.
        mem[2] = word(4000, 30);
        tick(1, 0);
        repeat (8) tick(0, 0);
        tick(0, 1);
        check("sat_duty2",  int'(bus.duty[2]),  2500);
        check("sat_phase2", int'(bus.phase[2]), 30);

        // Start during FETCH is ignored; commit waits for the next one.
        for (int e = 0; e < int'(DEPTH); e++) mem[e] = word(11 * (e + 1), 7 * (e + 1));
        tick(1, 0);
        tick(0, 1);
        tick(0, 0);
        tick(0, 1);
        repeat (5) tick(0, 0);
        check("hold_duty0", int'(bus.duty[0]), 100);
        tick(0, 1);
        check("late_duty0", int'(bus.duty[0]), 11);

        // Extra requests during FETCH collapse into one follow-up load.
        d0 = n_done_seen;
        tick(1, 0);
        tick(0, 0);
        tick(1, 0);
        tick(1, 0);
        for (int i = 0; i < 40; i++) tick(0, (i % 8) == 7);
        check("done_count_pending", n_done_seen - d0, 2);

        // Reset mid-FETCH after address 1 was issued.
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        rst_n = 1'b0;
        #1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_duty0", int'(bus.duty[0]), 0);
        tick(0, 0);
        tick(0, 0);
        rst_n = 1'b1;
        d0 = n_done_seen;
        for (int i = 0; i < 20; i++) tick(0, (i % 5) == 0);
        check("rst_no_done", n_done_seen - d0, 0);
        check("rst_no_load", int'(bus.busy), 0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            if (!m_loading && !m_pend && ($urandom_range(0, 3) == 0)) begin
                for (int e = 0; e < int'(DEPTH); e++) begin
                    if ($urandom_range(0, 1) == 0)
                        mem[e] = word(int'($urandom_range(0, 2500)), int'($urandom_range(0, 8191)));
                    else
                        mem[e] = $urandom;
                end
            end
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                tick(0, 0);
                rst_n = 1'b1;
            end else begin
                tick($urandom_range(0, 19) == 0, $urandom_range(0, 6) == 0);
            end
        end
        tick(0, 0);
        tick(0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_drive_param_loader
`default_nettype wire
